// File: rtl/bomb_place_arbiter.sv
// bomb_place_arbiter: shares the bomb map between players A and B.
// Arbitrates place requests round-robin, checks legality, writes new bombs,
// issues the periodic bomb_tick and tracks live bombs per player.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   req_a, ax, ay       player A place request pulse and cell coords
//   req_b, bx, by       player B place request pulse and cell coords
//   game_state          0 = running, otherwise placement refused
//   map_state           bomb map, cell 10*x+y at bits [2k+1:2k]
//   ack_a/b, nack_a/b   1-cycle result pulses per player
//   wr_en, wr_idx,      map write strobe, cell index, value (always 1)
//   wr_val
//   bomb_tick           1-cycle strobe advancing the bomb map
//   bombs_a, bombs_b    live bomb count per player
//   busy                arbiter FSM not idle
module bomb_place_arbiter #(
    parameter int TICK_DIV  = 50_000_000,
    parameter int MAX_BOMBS = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_a,
    input  logic [3:0]   ax,
    input  logic [3:0]   ay,
    input  logic         req_b,
    input  logic [3:0]   bx,
    input  logic [3:0]   by,
    input  logic [1:0]   game_state,
    input  logic [199:0] map_state,
    output logic         ack_a,
    output logic         ack_b,
    output logic         nack_a,
    output logic         nack_b,
    output logic         wr_en,
    output logic [6:0]   wr_idx,
    output logic [1:0]   wr_val,
    output logic         bomb_tick,
    output logic [2:0]   bombs_a,
    output logic [2:0]   bombs_b,
    output logic         busy
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);
    localparam logic [2:0] MAX_CNT = 3'(MAX_BOMBS);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CHECK = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_TICK  = 2'd3;

    localparam logic P_A = 1'b0;
    localparam logic P_B = 1'b1;

    logic [1:0]    r_state;
    logic [CW-1:0] r_tick_cnt;
    logic          r_tick_due;
    logic          r_pend_a;
    logic          r_pend_b;
    logic [3:0]    r_ax;
    logic [3:0]    r_ay;
    logic [3:0]    r_bx;
    logic [3:0]    r_by;
    logic          r_grant;
    logic          r_last;
    logic [99:0]   r_own_a;
    logic [99:0]   r_own_b;
    logic [2:0]    r_cnt_a;
    logic [2:0]    r_cnt_b;

    logic          w_run;
    logic          w_pick;
    logic [3:0]    w_x;
    logic [3:0]    w_y;
    logic [6:0]    w_idx;
    logic [1:0]    w_cell;
    logic          w_owned;
    logic          w_xy_ok;
    logic          w_cnt_ok;
    logic          w_legal;
    logic [99:0]   w_clr_a;
    logic [99:0]   w_clr_b;
    logic [6:0]    w_ncl_a;
    logic [6:0]    w_ncl_b;
    logic [2:0]    w_dec_a;
    logic [2:0]    w_dec_b;

    // Reset masks the strobes so a write caught mid-flight never lands.
    assign w_run = !rst;

    // On a tie the player not granted last time wins.
    assign w_pick = (r_pend_a && r_pend_b) ? ~r_last : r_pend_b;

    assign w_x = (r_grant == P_B) ? r_bx : r_ax;
    assign w_y = (r_grant == P_B) ? r_by : r_ay;

    // 10*x + y as 8*x + 2*x + y
    assign w_idx = {w_x, 3'b000}
                 + {2'b00, w_x, 1'b0}
                 + {3'b000, w_y};

    // Index only meaningful when coords are in range; w_xy_ok gates it.
    assign w_cell  = map_state[{w_idx, 1'b0} +: 2];
    assign w_owned = r_own_a[w_idx] | r_own_b[w_idx];

    assign w_xy_ok = (w_x >= 4'd1) && (w_x <= 4'd8)
                  && (w_y >= 4'd1) && (w_y <= 4'd8);

    assign w_cnt_ok = (r_grant == P_B) ? (r_cnt_b < MAX_CNT)
                                       : (r_cnt_a < MAX_CNT);

    assign w_legal = (game_state == 2'd0) && w_xy_ok
                  && (w_cell == 2'd0) && !w_owned && w_cnt_ok;

    // Owned cells that have exploded are released on a tick.
    always_comb begin
        w_clr_a = '0;
        w_clr_b = '0;
        for (int k = 0; k < 100; k++) begin
            w_clr_a[k] = r_own_a[k] && (map_state[2*k +: 2] == 2'd3);
            w_clr_b[k] = r_own_b[k] && (map_state[2*k +: 2] == 2'd3);
        end
    end

    assign w_ncl_a = 7'($countones(w_clr_a));
    assign w_ncl_b = 7'($countones(w_clr_b));

    assign w_dec_a = ({4'd0, r_cnt_a} <= w_ncl_a) ? 3'd0
                   : r_cnt_a - w_ncl_a[2:0];
    assign w_dec_b = ({4'd0, r_cnt_b} <= w_ncl_b) ? 3'd0
                   : r_cnt_b - w_ncl_b[2:0];

    assign wr_en     = w_run && (r_state == S_WRITE);
    assign wr_idx    = wr_en ? w_idx : 7'd0;
    assign wr_val    = wr_en ? 2'd1 : 2'd0;
    assign ack_a     = wr_en && (r_grant == P_A);
    assign ack_b     = wr_en && (r_grant == P_B);
    assign nack_a    = w_run && (r_state == S_CHECK)
                    && !w_legal && (r_grant == P_A);
    assign nack_b    = w_run && (r_state == S_CHECK)
                    && !w_legal && (r_grant == P_B);
    assign bomb_tick = w_run && (r_state == S_TICK);
    assign bombs_a   = r_cnt_a;
    assign bombs_b   = r_cnt_b;
    assign busy      = w_run && (r_state != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_tick_cnt <= '0;
            r_tick_due <= 1'b0;
            r_pend_a   <= 1'b0;
            r_pend_b   <= 1'b0;
            r_ax       <= 4'd0;
            r_ay       <= 4'd0;
            r_bx       <= 4'd0;
            r_by       <= 4'd0;
            r_grant    <= P_A;
            r_last     <= P_B;
            r_own_a    <= '0;
            r_own_b    <= '0;
            r_cnt_a    <= 3'd0;
            r_cnt_b    <= 3'd0;
        end else begin
            if (r_tick_cnt == TICK_LAST) begin
                r_tick_cnt <= '0;
            end else begin
                r_tick_cnt <= r_tick_cnt + CW'(1);
            end

            if (r_tick_cnt == TICK_LAST) begin
                r_tick_due <= 1'b1;
            end else if (r_state == S_TICK) begin
                r_tick_due <= 1'b0;
            end

            // A request arriving while one is pending is dropped.
            if (req_a && !r_pend_a) begin
                r_pend_a <= 1'b1;
                r_ax     <= ax;
                r_ay     <= ay;
            end
            if (req_b && !r_pend_b) begin
                r_pend_b <= 1'b1;
                r_bx     <= bx;
                r_by     <= by;
            end

            unique case (1'b1)
                (r_state == S_IDLE): begin
                    if (r_tick_due) begin
                        r_state <= S_TICK;
                    end else if (r_pend_a || r_pend_b) begin
                        r_grant <= w_pick;
                        r_last  <= w_pick;
                        r_state <= S_CHECK;
                    end
                end
                (r_state == S_CHECK): begin
                    if (w_legal) begin
                        r_state <= S_WRITE;
                    end else begin
                        if (r_grant == P_A) r_pend_a <= 1'b0;
                        else                r_pend_b <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                (r_state == S_WRITE): begin
                    if (r_grant == P_A) begin
                        r_cnt_a        <= r_cnt_a + 3'd1;
                        r_own_a[w_idx] <= 1'b1;
                        r_pend_a       <= 1'b0;
                    end else begin
                        r_cnt_b        <= r_cnt_b + 3'd1;
                        r_own_b[w_idx] <= 1'b1;
                        r_pend_b       <= 1'b0;
                    end
                    r_state <= S_IDLE;
                end
                (r_state == S_TICK): begin
                    r_own_a <= r_own_a & ~w_clr_a;
                    r_own_b <= r_own_b & ~w_clr_b;
                    r_cnt_a <= w_dec_a;
                    r_cnt_b <= w_dec_b;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bomb_place_arbiter.sv
// tb_bomb_place_arbiter: table vectors, hand sequences and random
// transactions against a transaction-level model of the arbiter.
module tb_bomb_place_arbiter;

    localparam int TD = 16;
    localparam int MB = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req_a = 1'b0;
    logic         req_b = 1'b0;
    logic [3:0]   ax = '0, ay = '0, bx = '0, by = '0;
    logic [1:0]   gs = '0;
    logic [199:0] map = '0;
    logic         ack_a, ack_b, nack_a, nack_b, wr_en, bomb_tick, busy;
    logic [6:0]   wr_idx;
    logic [1:0]   wr_val;
    logic [2:0]   bombs_a, bombs_b;

    bomb_place_arbiter #(.TICK_DIV(TD), .MAX_BOMBS(MB)) dut (
        .clk(clk), .rst(rst),
        .req_a(req_a), .ax(ax), .ay(ay),
        .req_b(req_b), .bx(bx), .by(by),
        .game_state(gs), .map_state(map),
        .ack_a(ack_a), .ack_b(ack_b),
        .nack_a(nack_a), .nack_b(nack_b),
        .wr_en(wr_en), .wr_idx(wr_idx), .wr_val(wr_val),
        .bomb_tick(bomb_tick),
        .bombs_a(bombs_a), .bombs_b(bombs_b),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    // Monitor: counts events; acts as the map memory for writes.
    int ev_ack_a = 0, ev_nack_a = 0, ev_ack_b = 0, ev_nack_b = 0;
    int ev_wr = 0, ev_tick = 0, last_idx = -1, cyc = 0;
    int ev_seq[$];
    int tick_cyc[$];

    always @(negedge clk) begin
        int i;
        cyc++;
        if (ack_a)  begin ev_ack_a++;  ev_seq.push_back(1); end
        if (nack_a) begin ev_nack_a++; ev_seq.push_back(1); end
        if (ack_b)  begin ev_ack_b++;  ev_seq.push_back(2); end
        if (nack_b) begin ev_nack_b++; ev_seq.push_back(2); end
        if (wr_en) begin
            ev_wr++;
            i = int'(wr_idx);
            last_idx = i;
            chk("wr_val", int'(wr_val), 1);
            chk("tick_with_wr", int'(bomb_tick), 0);
            if (i < 100) map[2*i +: 2] = 2'd1;
        end
        if (bomb_tick) begin
            ev_tick++;
            tick_cyc.push_back(cyc);
        end
    end

    // Reference model: owner sets, counts, last granted player.
    bit own_a[100];
    bit own_b[100];
    int cnt_a, cnt_b, last_p;

    task automatic reset_all();
        rst = 1'b1;
        req_a = 0; req_b = 0; gs = 0;
        map = '0;
        for (int k = 0; k < 100; k++) begin
            own_a[k] = 0; own_b[k] = 0;
        end
        cnt_a = 0; cnt_b = 0; last_p = 2;
        repeat (3) @(posedge clk);
        tick_cyc.push_back(-1);
        #1 rst = 1'b0;
    endtask

    task automatic model_try(input int p, input int x, input int y,
                             input int g, output bit ok);
        int idx;
        idx = 10*x + y;
        ok = (g == 0) && x >= 1 && x <= 8 && y >= 1 && y <= 8;
        if (ok) begin
            ok = (map[2*idx +: 2] == 2'd0) && !own_a[idx] && !own_b[idx]
              && (((p == 1) ? cnt_a : cnt_b) < MB);
        end
        if (ok) begin
            if (p == 1) begin own_a[idx] = 1; cnt_a++; end
            else        begin own_b[idx] = 1; cnt_b++; end
        end
        last_p = p;
    endtask

    int d_aa, d_na, d_ab, d_nb, d_wr, d_first;

    task automatic txn(input bit ra, input int xa, input int ya,
                       input bit rb, input int xb, input int yb,
                       input int g);
        int b_aa, b_na, b_ab, b_nb, b_wr, n;
        bit done;
        gs = 2'(g);
        b_aa = ev_ack_a; b_na = ev_nack_a;
        b_ab = ev_ack_b; b_nb = ev_nack_b; b_wr = ev_wr;
        ev_seq.delete();
        @(posedge clk); #1;
        req_a = ra; ax = 4'(xa); ay = 4'(ya);
        req_b = rb; bx = 4'(xb); by = 4'(yb);
        @(posedge clk); #1;
        req_a = 0; req_b = 0;
        n = 0; done = 0;
        while (!done && n < 40) begin
            @(posedge clk);
            n++;
            done = ((ev_ack_a - b_aa) + (ev_nack_a - b_na) >= int'(ra))
                && ((ev_ack_b - b_ab) + (ev_nack_b - b_nb) >= int'(rb));
        end
        chk("resp_timeout", int'(done), 1);
        repeat (3) @(posedge clk);
        #1;
        d_aa = ev_ack_a - b_aa; d_na = ev_nack_a - b_na;
        d_ab = ev_ack_b - b_ab; d_nb = ev_nack_b - b_nb;
        d_wr = ev_wr - b_wr;
        d_first = (ev_seq.size() > 0) ? ev_seq[0] : 0;
        gs = 0;
    endtask

    task automatic wait_tick();
        int base, n;
        base = ev_tick; n = 0;
        while (ev_tick == base && n < 40) begin
            @(posedge clk);
            n++;
        end
        chk("tick_timeout", int'(ev_tick != base), 1);
    endtask

    task automatic explode();
        int picks[$];
        int dec, x, y, n;
        for (int k = 0; k < 100; k++)
            if ((own_a[k] || own_b[k]) && $urandom_range(1, 0) == 1)
                picks.push_back(k);
        x = $urandom_range(8, 1); y = $urandom_range(8, 1);
        dec = 10*x + y;
        if (!own_a[dec] && !own_b[dec] && map[2*dec +: 2] == 2'd0)
            picks.push_back(dec);
        foreach (picks[i]) map[2*picks[i] +: 2] = 2'd3;
        wait_tick();
        @(posedge clk); #1;
        n = 0;
        foreach (picks[i]) if (own_a[picks[i]]) n++;
        cnt_a = (cnt_a > n) ? cnt_a - n : 0;
        n = 0;
        foreach (picks[i]) if (own_b[picks[i]]) n++;
        cnt_b = (cnt_b > n) ? cnt_b - n : 0;
        foreach (picks[i]) begin
            own_a[picks[i]] = 0; own_b[picks[i]] = 0;
            map[2*picks[i] +: 2] = 2'd0;
        end
        chk("boom_cnt_a", int'(bombs_a), cnt_a);
        chk("boom_cnt_b", int'(bombs_b), cnt_b);
    endtask

    typedef struct {
        bit rs; bit ra; int xa; int ya; bit rb; int xb; int yb; int g;
        int e_aa; int e_na; int e_ab; int e_nb; int e_wr; int e_idx;
        int e_first; int e_ca; int e_cb;
    } vec_t;

    vec_t tbl[11];

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok_a, ok_b;
        int ra, rb, xa, ya, xb, yb, g, kind, ef;
        int ea, eb, bs_wr, bs_ab;

        tbl[0]  = '{1,1,3,4,0,0,0,0, 1,0,0,0,1,34,1,1,0};
        tbl[1]  = '{1,1,2,2,1,5,5,0, 1,0,1,0,2,55,1,1,1};
        tbl[2]  = '{0,1,1,1,0,0,0,0, 1,0,0,0,1,11,1,2,1};
        tbl[3]  = '{0,1,6,6,1,8,8,0, 0,1,1,0,1,88,2,2,2};
        tbl[4]  = '{1,1,6,6,1,6,6,0, 1,0,0,1,1,66,1,1,0};
        tbl[5]  = '{0,1,0,5,1,9,1,0, 0,1,0,1,0,0,1,1,0};
        tbl[6]  = '{0,0,0,0,1,1,8,2, 0,0,0,1,0,0,2,1,0};
        tbl[7]  = '{0,1,6,6,0,0,0,0, 0,1,0,0,0,0,1,1,0};
        tbl[8]  = '{0,0,0,0,1,8,8,0, 0,0,1,0,1,88,2,1,1};
        tbl[9]  = '{0,1,4,0,0,0,0,0, 0,1,0,0,0,0,1,1,1};
        tbl[10] = '{0,1,5,6,1,5,5,1, 0,1,0,1,0,0,2,1,1};

        reset_all();
        chk("rst_bombs_a", int'(bombs_a), 0);
        chk("rst_bombs_b", int'(bombs_b), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_wr_en", int'(wr_en), 0);

        for (int v = 0; v < 11; v++) begin
            if (tbl[v].rs) reset_all();
            txn(tbl[v].ra, tbl[v].xa, tbl[v].ya,
                tbl[v].rb, tbl[v].xb, tbl[v].yb, tbl[v].g);
            chk($sformatf("v%0d_ack_a", v), d_aa, tbl[v].e_aa);
            chk($sformatf("v%0d_nack_a", v), d_na, tbl[v].e_na);
            chk($sformatf("v%0d_ack_b", v), d_ab, tbl[v].e_ab);
            chk($sformatf("v%0d_nack_b", v), d_nb, tbl[v].e_nb);
            chk($sformatf("v%0d_writes", v), d_wr, tbl[v].e_wr);
            if (tbl[v].e_wr > 0)
                chk($sformatf("v%0d_idx", v), last_idx, tbl[v].e_idx);
            chk($sformatf("v%0d_first", v), d_first, tbl[v].e_first);
            chk($sformatf("v%0d_bombs_a", v), int'(bombs_a), tbl[v].e_ca);
            chk($sformatf("v%0d_bombs_b", v), int'(bombs_b), tbl[v].e_cb);
        end

        // Limit, then explosion frees a slot.
        reset_all();
        txn(1, 2, 3, 0, 0, 0, 0);
        chk("lim_ack1", d_aa, 1);
        txn(1, 4, 5, 0, 0, 0, 0);
        chk("lim_ack2", d_aa, 1);
        txn(1, 6, 7, 0, 0, 0, 0);
        chk("lim_nack3", d_na, 1);
        chk("lim_cnt", int'(bombs_a), 2);
        map[2*23 +: 2] = 2'd3;
        wait_tick();
        @(posedge clk); #1;
        chk("boom_dec", int'(bombs_a), 1);
        map[2*23 +: 2] = 2'd0;
        txn(1, 6, 7, 0, 0, 0, 0);
        chk("refill_ack", d_aa, 1);
        chk("refill_cnt", int'(bombs_a), 2);

        // Reset in the middle of a write: nothing completes.
        wait_tick();
        #1;
        req_b = 1; bx = 4'd3; by = 4'd3;
        @(posedge clk); #1;
        req_b = 0;
        @(posedge clk);
        @(posedge clk); #1;
        chk("mid_busy", int'(busy), 1);
        chk("mid_wr_en", int'(wr_en), 1);
        bs_wr = ev_wr; bs_ab = ev_ack_b;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        tick_cyc.push_back(-1);
        #1 rst = 1'b0;
        cnt_a = 0; cnt_b = 0; last_p = 2;
        for (int k = 0; k < 100; k++) begin
            own_a[k] = 0; own_b[k] = 0;
        end
        map = '0;
        chk("mid_no_wr", ev_wr - bs_wr, 0);
        chk("mid_no_ack", ev_ack_b - bs_ab, 0);
        chk("mid_bombs_a", int'(bombs_a), 0);
        chk("mid_bombs_b", int'(bombs_b), 0);
        chk("mid_busy_after", int'(busy), 0);

        // Second pulse while pending is dropped.
        bs_wr = ev_wr;
        ev_seq.delete();
        @(posedge clk); #1;
        req_a = 1; ax = 4'd3; ay = 4'd3;
        @(posedge clk); #1;
        ax = 4'd4; ay = 4'd4;
        @(posedge clk); #1;
        req_a = 0;
        repeat (25) @(posedge clk);
        #1;
        chk("drop_events", ev_seq.size(), 1);
        chk("drop_writes", ev_wr - bs_wr, 1);
        chk("drop_idx", last_idx, 33);
        chk("drop_cnt", int'(bombs_a), 1);

        // Random transactions against the model.
        reset_all();
        for (int k = 0; k < 8; k++)
            map[2*(10*$urandom_range(8, 1) + $urandom_range(8, 1)) +: 2]
                = 2'd2;
        for (int t = 0; t < 80; t++) begin
            kind = $urandom_range(2, 0);
            ra = (kind != 1) ? 1 : 0;
            rb = (kind != 0) ? 1 : 0;
            xa = ($urandom_range(5, 0) == 0) ? $urandom_range(15, 0)
                                             : $urandom_range(8, 1);
            ya = $urandom_range(9, 0);
            xb = $urandom_range(8, 1);
            yb = ($urandom_range(5, 0) == 0) ? $urandom_range(15, 0)
                                             : $urandom_range(8, 1);
            if (ra == 1 && rb == 1 && $urandom_range(3, 0) == 0) begin
                xb = xa; yb = ya;
            end
            g = ($urandom_range(7, 0) == 0) ? $urandom_range(3, 1) : 0;
            ok_a = 0; ok_b = 0;
            if (ra == 1 && rb == 1) begin
                ef = (last_p == 1) ? 2 : 1;
                if (ef == 1) begin
                    model_try(1, xa, ya, g, ok_a);
                    model_try(2, xb, yb, g, ok_b);
                end else begin
                    model_try(2, xb, yb, g, ok_b);
                    model_try(1, xa, ya, g, ok_a);
                end
            end else if (ra == 1) begin
                ef = 1;
                model_try(1, xa, ya, g, ok_a);
            end else begin
                ef = 2;
                model_try(2, xb, yb, g, ok_b);
            end
            txn(ra[0], xa, ya, rb[0], xb, yb, g);
            ea = int'(ok_a); eb = int'(ok_b);
            chk("rnd_ack_a", d_aa, ea);
            chk("rnd_nack_a", d_na, ra - ea);
            chk("rnd_ack_b", d_ab, eb);
            chk("rnd_nack_b", d_nb, rb - eb);
            chk("rnd_writes", d_wr, ea + eb);
            chk("rnd_first", d_first, ef);
            chk("rnd_bombs_a", int'(bombs_a), cnt_a);
            chk("rnd_bombs_b", int'(bombs_b), cnt_b);
            if (t % 4 == 3) explode();
        end

        // Tick spacing: period TICK_DIV, shifted at most 2 by traffic.
        for (int i = 1; i < tick_cyc.size(); i++) begin
            if (tick_cyc[i] >= 0 && tick_cyc[i-1] >= 0)
                chk("tick_gap_ok",
                    int'((tick_cyc[i] - tick_cyc[i-1]) >= TD - 2
                      && (tick_cyc[i] - tick_cyc[i-1]) <= TD + 2), 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end

endmodule
